mem_cell_array: RTL

- Parametrised successor to the fixed 128x32 two-port memory cell used by the Huffman datapath.
- Port 1 is read/write and port 2 is read-only. Both ports have 1-cycle registered read latency and a valid strobe.
- Adds a hardware clear sweep, after reset and on demand, so that frequency and code tables start at a known value.
- Adds configurable same-address bypass from port 1 writes to port 2 reads.

---
 rtl/mem_cell_array.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_cell_array.sv
// rtl/mem_cell_array.sv - parametrised two-port memory cell with clear sweep
//
// Purpose: DEPTH x DATA_W memory. Port 1 reads and writes, port 2 only reads.
// Both read ports have a one-cycle registered latency and a valid strobe.
// A hardware sweep writes RESET_VAL to every entry after reset and whenever
// clear is requested. Until the sweep completes, ready is low and all port
// activity is ignored.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   clear      in   synchronous request to re-run the clear sweep
//   ready      out  memory accepts reads and writes
//   addr1      in   port 1 address
//   wen1       in   port 1 write enable
//   ren1       in   port 1 read enable
//   in_data1   in   port 1 write data
//   out_data1  out  port 1 registered read data
//   valid1     out  out_data1 updated this cycle
//   addr2      in   port 2 address
//   ren2       in   port 2 read enable
//   out_data2  out  port 2 registered read data
//   valid2     out  out_data2 updated this cycle

module mem_cell_array #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 7,
   parameter int                DEPTH     = 128,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter bit                BYPASS    = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   output logic              ready,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              wen1,
   input  logic              ren1,
   input  logic [DATA_W-1:0] in_data1,
   output logic [DATA_W-1:0] out_data1,
   output logic              valid1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic              ren2,
   output logic [DATA_W-1:0] out_data2,
   output logic              valid2
);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   // One extra bit so DEPTH == 2**ADDR_W can be compared without wrap.
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);

   logic [0:0]        state;
   logic [ADDR_W:0]   sweep;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range1;
   logic              in_range2;
   logic              active;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   assign in_range1 = ({1'b0, addr1} < DEPTH_V);
   assign in_range2 = ({1'b0, addr2} < DEPTH_V);
   // A clear request in READY wins over any port activity that cycle.
   assign active    = (state == ST_READY) && !clear;

   // Single shared write port: the sweep owns it during CLEAR, port 1 otherwise.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (state == ST_CLEAR) begin
         wr_en   = 1'b1;
         wr_addr = sweep[ADDR_W-1:0];
         wr_data = RESET_VAL;
      end else if (active && wen1 && in_range1) begin
         wr_en   = 1'b1;
         wr_addr = addr1;
         wr_data = in_data1;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Port 1 is write-first; port 2 sees the same-cycle write only with BYPASS.
   always_comb begin
      rd1 = RESET_VAL;
      rd2 = RESET_VAL;
      if (in_range1) begin
         rd1 = wen1 ? in_data1 : mem[addr1];
      end
      if (in_range2) begin
         if (BYPASS && wen1 && (addr1 == addr2)) begin
            rd2 = in_data1;
         end else begin
            rd2 = mem[addr2];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_CLEAR;
         sweep     <= '0;
         ready     <= 1'b0;
         valid1    <= 1'b0;
         valid2    <= 1'b0;
         out_data1 <= '0;
         out_data2 <= '0;
      end else begin
         valid1 <= 1'b0;
         valid2 <= 1'b0;
         if (state == ST_CLEAR) begin
            if (clear) begin
               sweep <= '0;
            end else if (sweep == LAST) begin
               state <= ST_READY;
               ready <= 1'b1;
               sweep <= '0;
            end else begin
               sweep <= sweep + 1'b1;
            end
         end else if (clear) begin
            state <= ST_CLEAR;
            sweep <= '0;
            ready <= 1'b0;
         end else begin
            valid1 <= ren1;
            valid2 <= ren2;
            if (ren1) begin
               out_data1 <= rd1;
            end
            if (ren2) begin
               out_data2 <= rd2;
            end
         end
      end
   end

endmodule
